// File: rtl/anemometer_speed_meter.sv
// ============================================================================
// Module   : anemometer_speed_meter
// Function : Debounced anemometer pulse counter with gated window, scaled
//            saturated speed, gust peak and optional 4-window average
//            (enable with `define ANEMO_AVG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anemometer_speed_meter #(
  parameter int CNT_W           = 8,
  parameter int SPEED_W         = 7,
  parameter int GATE_CYCLES     = 50000000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SPEED_NUM       = 376,
  parameter int SPEED_SHIFT     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rotation,
  input  logic               clear_peak,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] peak_speed,
  output logic [CNT_W-1:0]   pulse_count,
  output logic               speed_valid,
  output logic               overflow
`ifdef ANEMO_AVG_EN
  ,
  output logic [SPEED_W-1:0] speed_avg
`endif
);

  localparam int c_GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_PROD_W = CNT_W + 16;
  localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LOAD   =
      (DEBOUNCE_CYCLES > 0) ? c_DB_W'(DEBOUNCE_CYCLES - 1) : '0;
  localparam logic [c_PROD_W-1:0] c_SPEED_MAX = c_PROD_W'((64'd1 << SPEED_W) - 64'd1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  logic                r_sync1, r_sync2, r_sync3;
  state_t              r_state;
  logic [c_DB_W-1:0]   r_lock_cnt;
  logic [c_GATE_W-1:0] r_gate;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_win_ovf;

  logic                w_rise;
  logic                w_accept;
  logic                w_term;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_ovf_next;
  logic [c_PROD_W-1:0] w_prod;
  logic [c_PROD_W-1:0] w_scaled;
  logic [SPEED_W-1:0]  w_speed_new;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= rotation;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise   = r_sync2 & ~r_sync3;
  assign w_accept = w_rise && (r_state == ST_IDLE);

  // With a zero lockout the FSM never leaves IDLE, so every edge is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (DEBOUNCE_CYCLES != 0)) begin
            r_state    <= ST_LOCKOUT;
            r_lock_cnt <= c_DB_LOAD;
          end
        end
        ST_LOCKOUT: begin
          if (r_lock_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_term = (r_gate == c_GATE_LAST);

  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_win_ovf;
    if (w_accept) begin
      if (&r_cnt) begin
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // Scaling uses the count including any edge accepted on the terminal cycle.
  assign w_prod      = c_PROD_W'(w_cnt_next) * c_PROD_W'(SPEED_NUM);
  assign w_scaled    = w_prod >> SPEED_SHIFT;
  assign w_speed_new = (w_scaled > c_SPEED_MAX) ? {SPEED_W{1'b1}} : w_scaled[SPEED_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gate    <= '0;
      r_cnt     <= '0;
      r_win_ovf <= 1'b0;
    end else if (w_term) begin
      r_gate    <= '0;
      r_cnt     <= '0;
      r_win_ovf <= 1'b0;
    end else begin
      r_gate    <= r_gate + 1'b1;
      r_cnt     <= w_cnt_next;
      r_win_ovf <= w_ovf_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed       <= '0;
      pulse_count <= '0;
      overflow    <= 1'b0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= w_term;
      if (w_term) begin
        speed       <= w_speed_new;
        pulse_count <= w_cnt_next;
        overflow    <= w_ovf_next;
      end
    end
  end

  // Peak follows speed by one cycle so a clear on the strobe cycle keeps the new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_speed <= '0;
    end else if (speed_valid) begin
      if (clear_peak || (speed > peak_speed)) begin
        peak_speed <= speed;
      end
    end else if (clear_peak) begin
      peak_speed <= '0;
    end
  end

`ifdef ANEMO_AVG_EN
  // The current speed register is the newest of the three previous entries.
  logic [SPEED_W-1:0] r_hist0, r_hist1;
  logic [SPEED_W+1:0] w_sum;

  assign w_sum = {2'b00, w_speed_new} + {2'b00, speed} + {2'b00, r_hist0} + {2'b00, r_hist1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist0   <= '0;
      r_hist1   <= '0;
      speed_avg <= '0;
    end else if (w_term) begin
      r_hist0   <= speed;
      r_hist1   <= r_hist0;
      speed_avg <= w_sum[SPEED_W+1:2];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_anemometer_speed_meter.sv
// ============================================================================
// Module   : tb_anemometer_speed_meter
// Function : Self-checking bench for anemometer_speed_meter (window-level
//            reference model, vector table, directed corner sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anemometer_speed_meter;

  localparam int GATE = 100;
  localparam int DB   = 4;
  localparam int CW   = 4;
  localparam int SW   = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rotation = 1'b0;
  logic          clear_peak = 1'b0;
  logic [SW-1:0] speed, peak_speed;
  logic [CW-1:0] pulse_count;
  logic          speed_valid, overflow;
`ifdef ANEMO_AVG_EN
  logic [SW-1:0] speed_avg;
`endif

  anemometer_speed_meter #(
    .CNT_W(CW), .SPEED_W(SW), .GATE_CYCLES(GATE), .DEBOUNCE_CYCLES(DB),
    .SPEED_NUM(376), .SPEED_SHIFT(8)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .rotation(rotation), .clear_peak(clear_peak),
    .speed(speed), .peak_speed(peak_speed), .pulse_count(pulse_count),
    .speed_valid(speed_valid), .overflow(overflow)
`ifdef ANEMO_AVG_EN
    , .speed_avg(speed_avg)
`endif
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state, expressed per window rather than per register.
  int m_cyc;
  bit m_rot[$];
  int m_last_acc, m_cnt;
  int m_speed, m_pc, m_ovf, m_peak, m_avg;
  int m_hist[4];
  bit m_valid;

  typedef struct {
    int np; int hi; int lo;
    int exp_pc; int exp_speed; int exp_ovf;
  } win_t;
  win_t tbl[4];

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  function automatic int scale(input int n);
    int v;
    v = (n * 376) >> 8;
    return (v > 127) ? 127 : v;
  endfunction

  function automatic bit pulse_at(input int k, input int np, input int hi, input int lo);
    return ((k / (hi + lo)) < np) && ((k % (hi + lo)) < hi);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_rot.delete(); m_last_acc = -1000; m_cnt = 0;
    m_speed = 0; m_pc = 0; m_ovf = 0; m_peak = 0; m_avg = 0; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  endtask

  task automatic check_all();
    check("valid", speed_valid, int'(m_valid));
    check("speed", speed, m_speed);
    check("pulse_count", pulse_count, m_pc);
    check("overflow", overflow, m_ovf);
    check("peak", peak_speed, m_peak);
`ifdef ANEMO_AVG_EN
    check("avg", speed_avg, m_avg);
`endif
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit cl);
    bit p2, p3;
    rotation = r; clear_peak = cl;
    if (m_valid) m_peak = (cl || m_speed > m_peak) ? m_speed : m_peak;
    else if (cl) m_peak = 0;
    p2 = (m_cyc >= 2) ? m_rot[m_cyc-2] : 1'b0;
    p3 = (m_cyc >= 3) ? m_rot[m_cyc-3] : 1'b0;
    m_rot.push_back(r);
    if (p2 && !p3 && (m_cyc - m_last_acc > DB)) begin
      m_cnt++;
      m_last_acc = m_cyc;
    end
    m_valid = ((m_cyc % GATE) == GATE - 1);
    if (m_valid) begin
      m_pc = (m_cnt > 15) ? 15 : m_cnt;
      m_ovf = (m_cnt > 15) ? 1 : 0;
      m_speed = scale(m_pc);
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_speed;
      m_avg = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) >> 2;
      m_cnt = 0;
    end
    @(posedge clk); #1;
    m_cyc++;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_speed"}, speed, 0);
    check({tag, "_peak"}, peak_speed, 0);
    check({tag, "_pc"}, pulse_count, 0);
    check({tag, "_valid"}, speed_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1 check_zero("rst_async");
    for (int i = 0; i < n; i++) begin
      rotation = i[0];
      @(posedge clk); #1;
      check_zero("rst_hold");
    end
    rotation = 1'b0; clear_peak = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Runs to the end of the current window; ends sampling the strobe cycle.
  task automatic run_window(input int np, input int hi, input int lo,
                            input int clr_at, input int clr_exp);
    int k;
    do begin
      k = m_cyc % GATE;
      step(pulse_at(k, np, hi, lo), k == clr_at);
      if (k == clr_at) check("peak_after_clear", peak_speed, clr_exp);
    end while ((m_cyc % GATE) != 0);
  endtask

  initial begin
    int hold, maxh;
    bit lvl;
    tbl[0] = '{0, 3, 10, 0, 0, 0};
    tbl[1] = '{5, 3, 10, 5, 7, 0};
    tbl[2] = '{16, 3, 3, 15, 22, 1};
    tbl[3] = '{1, 3, 10, 1, 1, 0};

    #2;
    do_reset(6);

    // Strobe must not appear before cycle 100.
    for (int i = 0; i < 99; i++) step(1'b0, 1'b0);
    check("no_early_valid", speed_valid, 0);
    step(1'b0, 1'b0);
    check("first_valid_at_100", speed_valid, 1);
    for (int i = 1; i < 4; i++) begin
      run_window(tbl[i].np, tbl[i].hi, tbl[i].lo, -1, 0);
      check($sformatf("tbl%0d_valid", i), speed_valid, 1);
      check($sformatf("tbl%0d_pc", i), pulse_count, tbl[i].exp_pc);
      check($sformatf("tbl%0d_speed", i), speed, tbl[i].exp_speed);
      check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
    end
    check("tbl0_speed_zero", int'(tbl[0].exp_speed), 0 + 0 * m_cyc);

    // Bounce burst followed by one clean pulse.
    do begin
      int k;
      k = m_cyc % GATE;
      step((k == 5 || k == 7 || k == 9 || (k >= 20 && k <= 22)), 1'b0);
    end while ((m_cyc % GATE) != 0);
    check("bounce_pc", pulse_count, 2);

    run_window(0, 3, 10, 50, 0);
    run_window(5, 3, 10, -1, 0);
    check("peak_win7_speed", speed, 7);
    run_window(2, 3, 10, -1, 0);
    check("peak_hold_7", peak_speed, 7);
    run_window(3, 3, 10, 60, 0);
    check("speed4", speed, 4);
    run_window(0, 3, 10, 0, 4);

    // Reset asserted mid-window after three pulses.
    for (int k = 0; k < 50; k++) step(pulse_at(k, 3, 3, 10), 1'b0);
    do_reset(3);
    run_window(2, 3, 10, -1, 0);
    check("post_reset_valid", speed_valid, 1);
    check("post_reset_pc", pulse_count, 2);

    // Randomised rotation with varying density, checked against the model.
    lvl = 1'b0; hold = 1;
    for (int w = 0; w < 10; w++) begin
      maxh = $urandom_range(2, 12);
      do begin
        if (--hold == 0) begin
          lvl = ~lvl;
          hold = $urandom_range(1, maxh);
        end
        step(lvl, $urandom_range(0, 63) == 0);
      end while ((m_cyc % GATE) != 0);
    end

`ifdef ANEMO_AVG_EN
    do_reset(2);
    for (int i = 1; i <= 4; i++) begin
      run_window(6, 3, 10, -1, 0);
      check($sformatf("avg_speed%0d", i), speed, 8);
      check($sformatf("avg%0d", i), speed_avg, 2 * i);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
